// File: rtl/serial_tx.sv
// serial_tx: UART-style serializer sending start bit, LSB-first payload and stop bit
module serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] sh;
    logic                 last;

    assign last     = cnt == CW'(CLKS_PER_BIT - 1);
    assign tx_ready = state == IDLE;
    assign busy     = ~tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tx    <= 1'b1;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            case (state)
                IDLE:
                    if (tx_valid) begin
                        state <= START;
                        sh    <= tx_data;
                        cnt   <= '0;
                        tx    <= 1'b0;
                    end else begin
                        tx <= 1'b1;
                    end
                START:
                    if (last) begin
                        state <= DATA;
                        cnt   <= '0;
                        idx   <= '0;
                        tx    <= sh[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                DATA:
                    if (last) begin
                        cnt <= '0;
                        if (idx == IW'(DATA_BITS - 1)) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            sh  <= sh >> 1;
                            tx  <= sh[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                STOP:
                    if (last) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: per-cycle queue model of expected line values checked against two DUTs
module tb_serial_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       tx0, rdy0, busy0, tx1, rdy1, busy1;
    int         n_chk = 0, n_fail = 0;
    bit         q0[$], q1[$];

    serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .tx_valid(v0), .tx_data(d0),
        .tx_ready(rdy0), .tx(tx0), .busy(busy0)
    );
    serial_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
        .clk(clk), .reset(reset), .tx_valid(v1), .tx_data(d1),
        .tx_ready(rdy1), .tx(tx1), .busy(busy1)
    );

    always #5 clk = ~clk;

    function automatic bit fbit(input logic [7:0] d, input int k);
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : d[k-1];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The model holds the line value for each upcoming cycle; an empty queue means idle.
    always @(posedge clk) begin
        if (!reset) begin
            if (q0.size() != 0) void'(q0.pop_front());
            else if (v0) for (int k = 0; k < 10; k++) repeat (4) q0.push_back(fbit(d0, k));
            if (q1.size() != 0) void'(q1.pop_front());
            else if (v1) for (int k = 0; k < 10; k++) q1.push_back(fbit(d1, k));
        end
    end

    always @(posedge reset) begin
        q0.delete();
        q1.delete();
    end

    always @(negedge clk) begin
        chk("model tx0", {31'd0, tx0}, {31'd0, q0.size() != 0 ? q0[0] : 1'b1});
        chk("model ready0", {31'd0, rdy0}, {31'd0, q0.size() == 0});
        chk("model busy0", {31'd0, busy0}, {31'd0, q0.size() != 0});
        chk("model tx1", {31'd0, tx1}, {31'd0, q1.size() != 0 ? q1[0] : 1'b1});
        chk("model ready1", {31'd0, rdy1}, {31'd0, q1.size() == 0});
        chk("model busy1", {31'd0, busy1}, {31'd0, q1.size() != 0});
    end

    // Call at the first negedge after acceptance; pat bit k is frame bit k.
    task automatic frame0(input string name, input logic [9:0] pat);
        for (int i = 0; i < 40; i++) begin
            chk({name, " tx"}, {31'd0, tx0}, {31'd0, pat[i/4]});
            chk({name, " busy"}, {31'd0, busy0}, 32'd1);
            chk({name, " ready"}, {31'd0, rdy0}, 32'd0);
            @(negedge clk);
        end
        chk({name, " end ready"}, {31'd0, rdy0}, 32'd1);
        chk({name, " end tx"}, {31'd0, tx0}, 32'd1);
    endtask

    initial begin
        v0 = 1'b1;
        d0 = 8'hFF;
        v1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset tx", {31'd0, tx0}, 32'd1);
        chk("reset ready", {31'd0, rdy0}, 32'd1);
        chk("reset busy", {31'd0, busy0}, 32'd0);
        v0 = 1'b0;
        v1 = 1'b0;
        reset = 1'b0;
        repeat (50) begin
            @(negedge clk);
            chk("idle tx", {31'd0, tx0}, 32'd1);
            chk("idle ready", {31'd0, rdy0}, 32'd1);
        end
        v0 = 1'b1;
        d0 = 8'hA5;
        @(negedge clk);
        v0 = 1'b0;
        frame0("A5", 10'b1101001010);
        v0 = 1'b1;
        d0 = 8'h3C;
        @(negedge clk);
        d0 = 8'hC3;
        repeat (40) @(negedge clk);
        chk("b2b gap ready", {31'd0, rdy0}, 32'd1);
        chk("b2b gap tx", {31'd0, tx0}, 32'd1);
        @(negedge clk);
        v0 = 1'b0;
        chk("b2b second start", {31'd0, tx0}, 32'd0);
        chk("b2b second busy", {31'd0, busy0}, 32'd1);
        repeat (4) @(negedge clk);
        chk("b2b C3 bit0", {31'd0, tx0}, 32'd1);
        repeat (36) @(negedge clk);
        v0 = 1'b1;
        d0 = 8'hFF;
        @(negedge clk);
        v0 = 1'b0;
        d0 = 8'h00;
        repeat (10) @(negedge clk);
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        repeat (23) @(negedge clk);
        chk("FF data last bit", {31'd0, tx0}, 32'd1);
        repeat (6) @(negedge clk);
        chk("FF done ready", {31'd0, rdy0}, 32'd1);
        @(negedge clk);
        chk("no queued frame", {31'd0, busy0}, 32'd0);
        v0 = 1'b1;
        d0 = 8'h00;
        @(negedge clk);
        v0 = 1'b0;
        repeat (17) @(negedge clk);
        chk("00 cycle17 tx", {31'd0, tx0}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("abort tx", {31'd0, tx0}, 32'd1);
        chk("abort ready", {31'd0, rdy0}, 32'd1);
        chk("abort busy", {31'd0, busy0}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        v0 = 1'b1;
        d0 = 8'h81;
        @(negedge clk);
        v0 = 1'b0;
        frame0("81", 10'b1100000010);
        v1 = 1'b1;
        d1 = 8'h01;
        @(negedge clk);
        v1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("cpb1 tx", {31'd0, tx1}, {31'd0, i == 1 || i == 9});
            @(negedge clk);
        end
        chk("cpb1 end ready", {31'd0, rdy1}, 32'd1);
        v1 = 1'b1;
        d1 = 8'h5A;
        repeat (25) @(negedge clk);
        v1 = 1'b0;
        repeat (12) @(negedge clk);
        chk("cpb1 b2b idle", {31'd0, rdy1}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
